// File: rtl/sram_arbiter_if.sv
// Bundles the fetch port, the execution port and the SRAM pins of the arbiter.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface sram_arbiter_if #(
   parameter int SRAM_ADDR_SIZE = 15,
   parameter int DATA_SIZE      = 8
);
   logic [SRAM_ADDR_SIZE-1:0] if_addr;
   logic                      if_rd_en;
   logic [DATA_SIZE-1:0]      if_d_out;
   logic                      if_ack;

   logic [SRAM_ADDR_SIZE-1:0] ex_addr;
   logic                      ex_rd_en;
   logic                      ex_wr_en;
   logic [DATA_SIZE-1:0]      ex_d_in;
   logic [DATA_SIZE-1:0]      ex_d_out;
   logic                      ex_ack;

   logic [SRAM_ADDR_SIZE-1:0] sram_addr;
   logic                      sram_oe_n;
   logic                      sram_we_n;
   logic                      sram_ce_n;
   logic [DATA_SIZE-1:0]      sram_dq_out;
   logic                      sram_dq_oe;
   logic [DATA_SIZE-1:0]      sram_dq_in;

   modport slave (
      input  if_addr, if_rd_en, ex_addr, ex_rd_en, ex_wr_en, ex_d_in, sram_dq_in,
      output if_d_out, if_ack, ex_d_out, ex_ack,
             sram_addr, sram_oe_n, sram_we_n, sram_ce_n, sram_dq_out, sram_dq_oe
   );

   modport master (
      output if_addr, if_rd_en, ex_addr, ex_rd_en, ex_wr_en, ex_d_in, sram_dq_in,
      input  if_d_out, if_ack, ex_d_out, ex_ack,
             sram_addr, sram_oe_n, sram_we_n, sram_ce_n, sram_dq_out, sram_dq_oe
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (fetch / execution) arbiter in front of a single asynchronous SRAM,
// with alternating priority and a fixed number of wait states per access.
//
// state  | meaning
// IDLE   | no access; grants are made only here
// ACCESS | SRAM cycle in progress, WAIT_STATES+1 cycles long
// DONE   | one-cycle ack to the granted port, strobes inactive
module sram_arbiter #(
   parameter int SRAM_ADDR_SIZE = 15,
   parameter int DATA_SIZE      = 8,
   parameter int WAIT_STATES    = 2
) (
   input  logic           clk,
   input  logic           reset,
   sram_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [2:0]                cnt;
   logic                      rst_done;
   logic                      last_ex;
   logic                      port_ex;
   logic                      write_q;
   logic [SRAM_ADDR_SIZE-1:0] addr_q;
   logic [DATA_SIZE-1:0]      data_q;
   logic [DATA_SIZE-1:0]      if_data_q;
   logic [DATA_SIZE-1:0]      ex_data_q;

   logic if_req;
   logic ex_req;
   logic pick_ex;
   logic grant;
   logic last_access;

   assign if_req      = bus.if_rd_en;
   assign ex_req      = bus.ex_rd_en | bus.ex_wr_en;
   // Execution port wins when alone, or when both ask and fetch was served last.
   assign pick_ex     = ex_req & (~if_req | ~last_ex);
   // rst_done holds off the first grant until the second edge after reset release.
   assign grant       = (state == IDLE) & rst_done & (if_req | ex_req);
   assign last_access = (state == ACCESS) && (cnt == 3'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = ACCESS;
         ACCESS:  if (cnt == 3'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= 3'd0;
         rst_done  <= 1'b0;
         last_ex   <= 1'b1;
         port_ex   <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         if_data_q <= '0;
         ex_data_q <= '0;
      end else begin
         rst_done <= 1'b1;
         if (grant) begin
            cnt     <= 3'(WAIT_STATES);
            last_ex <= pick_ex;
            port_ex <= pick_ex;
            write_q <= pick_ex & bus.ex_wr_en;
            addr_q  <= pick_ex ? bus.ex_addr : bus.if_addr;
            data_q  <= bus.ex_d_in;
         end else if (state == ACCESS && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
         end
         if (last_access && !write_q) begin
            if (port_ex) ex_data_q <= bus.sram_dq_in;
            else         if_data_q <= bus.sram_dq_in;
         end
      end
   end

   always_comb begin
      bus.sram_ce_n  = 1'b1;
      bus.sram_oe_n  = 1'b1;
      bus.sram_we_n  = 1'b1;
      bus.sram_dq_oe = 1'b0;
      bus.if_ack     = 1'b0;
      bus.ex_ack     = 1'b0;
      case (state)
         ACCESS: begin
            bus.sram_ce_n = 1'b0;
            if (write_q) begin
               bus.sram_dq_oe = 1'b1;
               // Release we_n one cycle early so data holds past the write edge.
               bus.sram_we_n  = ~((cnt != 3'd0) || (WAIT_STATES == 0));
            end else begin
               bus.sram_oe_n = 1'b0;
            end
         end
         DONE: begin
            bus.if_ack = ~port_ex;
            bus.ex_ack = port_ex;
         end
         default: ;
      endcase
   end

   assign bus.sram_addr   = addr_q;
   assign bus.sram_dq_out = data_q;
   assign bus.if_d_out    = if_data_q;
   assign bus.ex_d_out    = ex_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with WAIT_STATES=2: single-port reads and
// writes, alternating arbitration, reset behaviour and mid-access reset.
module tb_sram_arbiter;

   logic clk;
   logic reset;

   sram_arbiter_if #(.SRAM_ADDR_SIZE(15), .DATA_SIZE(8)) bus ();

   sram_arbiter #(.SRAM_ADDR_SIZE(15), .DATA_SIZE(8), .WAIT_STATES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   int ce_lo, oe_lo, we_lo, dqoe_hi, addr_err, dq_err, if_acks, ex_acks, ack_step, dbl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps negedge by negedge until an ack is seen (or n_max steps pass), tallying
   // strobe activity; scrambles requester inputs once the access has started.
   task automatic run_txn(input int n_max, input logic [14:0] exp_addr, input logic [7:0] exp_dq);
      bit scrambled = 0;
      ce_lo = 0; oe_lo = 0; we_lo = 0; dqoe_hi = 0; addr_err = 0; dq_err = 0;
      if_acks = 0; ex_acks = 0; ack_step = 0; dbl = 0;
      for (int s = 1; s <= n_max; s++) begin
         @(negedge clk);
         if (!bus.sram_ce_n) begin
            ce_lo++;
            if (bus.sram_addr !== exp_addr) addr_err++;
         end
         if (!bus.sram_oe_n) oe_lo++;
         if (!bus.sram_we_n) we_lo++;
         if (bus.sram_dq_oe) begin
            dqoe_hi++;
            if (bus.sram_dq_out !== exp_dq) dq_err++;
         end
         if (bus.if_ack) if_acks++;
         if (bus.ex_ack) ex_acks++;
         if (bus.if_ack && bus.ex_ack) dbl++;
         if (!bus.sram_ce_n && !scrambled) begin
            scrambled   = 1;
            bus.if_addr = ~bus.if_addr;
            bus.ex_addr = ~bus.ex_addr;
            bus.ex_d_in = ~bus.ex_d_in;
         end
         if (bus.if_ack || bus.ex_ack) begin
            ack_step     = s;
            bus.if_rd_en = 1'b0;
            bus.ex_rd_en = 1'b0;
            bus.ex_wr_en = 1'b0;
            break;
         end
      end
   endtask

   int n_ack;
   int ack_at [4];
   logic ack_ex [4];

   initial begin
      reset          = 1'b0;
      bus.if_addr    = 15'h1234;
      bus.if_rd_en   = 1'b1;
      bus.ex_addr    = '0;
      bus.ex_rd_en   = 1'b0;
      bus.ex_wr_en   = 1'b0;
      bus.ex_d_in    = '0;
      bus.sram_dq_in = 8'hA5;

      @(negedge clk);
      @(negedge clk);
      chk("rst_ce_n",   32'(bus.sram_ce_n),  1);
      chk("rst_oe_n",   32'(bus.sram_oe_n),  1);
      chk("rst_we_n",   32'(bus.sram_we_n),  1);
      chk("rst_dq_oe",  32'(bus.sram_dq_oe), 0);
      chk("rst_addr",   32'(bus.sram_addr),  0);
      chk("rst_if_ack", 32'(bus.if_ack),     0);
      chk("rst_ex_ack", 32'(bus.ex_ack),     0);
      chk("rst_if_d",   32'(bus.if_d_out),   0);
      chk("rst_ex_d",   32'(bus.ex_d_out),   0);

      // Fetch read 0x1234 -> 0xA5; request already pending at reset release.
      reset = 1'b1;
      @(negedge clk);
      chk("no_grant_first_edge", 32'(bus.sram_ce_n), 1);
      run_txn(6, 15'h1234, 8'h00);
      chk("if_rd_ack_step",  32'(ack_step + 1), 5);
      chk("if_rd_oe_lo",     32'(oe_lo), 3);
      chk("if_rd_ce_lo",     32'(ce_lo), 3);
      chk("if_rd_we_lo",     32'(we_lo), 0);
      chk("if_rd_addr_err",  32'(addr_err), 0);
      chk("if_rd_acks",      32'(if_acks * 16 + ex_acks), 16);
      chk("if_rd_data",      32'(bus.if_d_out), 'hA5);
      @(negedge clk);
      chk("if_rd_ack_pulse", 32'(bus.if_ack), 0);

      // Execution write 0x0010 <- 0x3C.
      bus.ex_addr = 15'h0010; bus.ex_d_in = 8'h3C; bus.ex_wr_en = 1'b1;
      run_txn(6, 15'h0010, 8'h3C);
      chk("ex_wr_ack_step", 32'(ack_step), 4);
      chk("ex_wr_we_lo",    32'(we_lo), 2);
      chk("ex_wr_dqoe_hi",  32'(dqoe_hi), 3);
      chk("ex_wr_dq_err",   32'(dq_err), 0);
      chk("ex_wr_oe_lo",    32'(oe_lo), 0);
      chk("ex_wr_addr_err", 32'(addr_err), 0);
      chk("ex_wr_acks",     32'(if_acks * 16 + ex_acks), 1);
      chk("ex_wr_d_out",    32'(bus.ex_d_out), 0);
      @(negedge clk);
      chk("ex_wr_ack_pulse", 32'(bus.ex_ack), 0);

      // Execution read 0x0030 -> 0xC3; fetch data must stay put.
      bus.ex_addr = 15'h0030; bus.ex_rd_en = 1'b1; bus.sram_dq_in = 8'hC3;
      run_txn(6, 15'h0030, 8'h00);
      chk("ex_rd_ack_step", 32'(ack_step), 4);
      chk("ex_rd_oe_lo",    32'(oe_lo), 3);
      chk("ex_rd_data",     32'(bus.ex_d_out), 'hC3);
      chk("ex_rd_if_hold",  32'(bus.if_d_out), 'hA5);
      @(negedge clk);

      // Read and write together behave as a write; ex_d_out keeps 0xC3.
      bus.ex_addr = 15'h0020; bus.ex_d_in = 8'h5A; bus.ex_rd_en = 1'b1; bus.ex_wr_en = 1'b1;
      bus.sram_dq_in = 8'h11;
      run_txn(6, 15'h0020, 8'h5A);
      chk("rdwr_oe_lo",   32'(oe_lo), 0);
      chk("rdwr_we_lo",   32'(we_lo), 2);
      chk("rdwr_dq_err",  32'(dq_err), 0);
      chk("rdwr_ex_hold", 32'(bus.ex_d_out), 'hC3);
      @(negedge clk);

      // Both ports requesting from reset: last grant resets to EX, so IF goes first.
      reset = 1'b0;
      bus.if_addr = 15'h0001; bus.ex_addr = 15'h0002;
      bus.if_rd_en = 1'b1; bus.ex_rd_en = 1'b1; bus.sram_dq_in = 8'h66;
      @(negedge clk);
      chk("rst2_if_d", 32'(bus.if_d_out), 0);
      chk("rst2_ex_d", 32'(bus.ex_d_out), 0);
      reset = 1'b1;
      n_ack = 0; dbl = 0;
      for (int s = 1; s <= 20; s++) begin
         @(negedge clk);
         if (bus.if_ack && bus.ex_ack) dbl++;
         if ((bus.if_ack || bus.ex_ack) && n_ack < 4) begin
            ack_at[n_ack] = s;
            ack_ex[n_ack] = bus.ex_ack;
            n_ack++;
         end
      end
      bus.if_rd_en = 1'b0; bus.ex_rd_en = 1'b0;
      chk("alt_n_ack",  32'(n_ack), 4);
      chk("alt_dbl",    32'(dbl), 0);
      chk("alt_order",  32'({ack_ex[0], ack_ex[1], ack_ex[2], ack_ex[3]}), 'b0101);
      chk("alt_first",  32'(ack_at[0]), 5);
      chk("alt_gap1",   32'(ack_at[1] - ack_at[0]), 5);
      chk("alt_gap2",   32'(ack_at[2] - ack_at[1]), 5);
      chk("alt_gap3",   32'(ack_at[3] - ack_at[2]), 5);
      chk("alt_data",   32'({bus.if_d_out, bus.ex_d_out}), 'h6666);
      @(negedge clk);

      // Reset in the second ACCESS cycle: strobes drop at once, no ack follows.
      bus.if_addr = 15'h0100; bus.if_rd_en = 1'b1; bus.sram_dq_in = 8'h77;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("mid_pre_ce_n", 32'(bus.sram_ce_n), 0);
      reset = 1'b0;
      #1;
      chk("mid_ce_n", 32'(bus.sram_ce_n), 1);
      chk("mid_oe_n", 32'(bus.sram_oe_n), 1);
      bus.if_rd_en = 1'b0;
      if_acks = 0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         if (bus.if_ack || bus.ex_ack) if_acks++;
      end
      chk("mid_no_ack", 32'(if_acks), 0);
      chk("mid_if_d",   32'(bus.if_d_out), 0);

      reset = 1'b1;
      bus.ex_addr = 15'h0200; bus.ex_rd_en = 1'b1; bus.sram_dq_in = 8'h99;
      run_txn(8, 15'h0200, 8'h00);
      chk("post_ack_step", 32'(ack_step), 5);
      chk("post_acks",     32'(if_acks * 16 + ex_acks), 1);
      chk("post_oe_lo",    32'(oe_lo), 3);
      chk("post_addr_err", 32'(addr_err), 0);
      chk("post_ex_d",     32'(bus.ex_d_out), 'h99);
      chk("post_if_d",     32'(bus.if_d_out), 0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
